// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state encoding and default widths for alu_opseq
package alu_pkg;
    localparam int N_DEF = 4;
    localparam int CW_DEF = 8;
    typedef enum logic [1:0] {LOAD_A, LOAD_B, EXEC, RESULT} state_t;
endpackage

// File: rtl/alu_opseq.sv
// alu_opseq: two-word operand sequencer around an external OR unit; ALU_OPSEQ_ZERO_EN adds res_zero
module alu_opseq
    import alu_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          flush,
    output logic [N-1:0]  op_a,
    output logic [N-1:0]  op_b,
    input  logic [N-1:0]  op_c,
    output logic [N-1:0]  res,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef ALU_OPSEQ_ZERO_EN
    output logic          res_zero,
`endif
    output logic [CW-1:0] op_cnt
);
    state_t state;
    assign in_ready = (state == LOAD_A) || (state == LOAD_B);
`ifdef ALU_OPSEQ_ZERO_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            res_zero <= 1'b0;
        else if (!flush && state == EXEC)
            res_zero <= (op_c == '0);
`endif
    // flush has priority over every load, capture and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_A;
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            out_valid <= 1'b0;
            op_cnt    <= '0;
        end else if (flush) begin
            state     <= LOAD_A;
            out_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: if (in_valid) begin
                    op_a  <= in_data;
                    state <= LOAD_B;
                end
                LOAD_B: if (in_valid) begin
                    op_b  <= in_data;
                    state <= EXEC;
                end
                EXEC: begin
                    res       <= op_c;
                    out_valid <= 1'b1;
                    state     <= RESULT;
                end
                RESULT: if (out_ready) begin
                    out_valid <= 1'b0;
                    op_cnt    <= op_cnt + CW'(1);
                    state     <= LOAD_A;
                end
                default: state <= LOAD_A;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_opseq.sv
// tb_alu_opseq: directed table-driven bench for alu_opseq with an OR-unit model
module tb_alu_opseq;
    localparam int N = 4;
    localparam int CW = 8;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [N-1:0] in_data = '0;
    logic in_ready, out_valid;
    logic [N-1:0] op_a, op_b, op_c, res;
    logic [CW-1:0] op_cnt;
    logic [CW-1:0] cnt = '0;
`ifdef ALU_OPSEQ_ZERO_EN
    logic res_zero;
`endif
    int checks = 0, errors = 0;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp;
    } vec_t;
    vec_t vecs[8];

    assign op_c = op_a | op_b;
    always #5 clk = ~clk;

    alu_opseq #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .res(res), .out_valid(out_valid), .out_ready(out_ready),
`ifdef ALU_OPSEQ_ZERO_EN
        .res_zero(res_zero),
`endif
        .op_cnt(op_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drives A then B back to back and leaves the DUT in RESULT
    task automatic load(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] exp);
        in_valid = 1'b1;
        in_data = a;
        step();
        chk("after_a_in_ready", in_ready, 1);
        chk("op_a_load", op_a, a);
        in_data = b;
        step();
        in_valid = 1'b0;
        chk("op_b_load", op_b, b);
        chk("exec_in_ready", in_ready, 0);
        chk("exec_out_valid", out_valid, 0);
        step();
        chk("result_out_valid", out_valid, 1);
        chk("result_in_ready", in_ready, 0);
        chk("res", res, exp);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        cnt++;
        chk("op_cnt", op_cnt, cnt);
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        vecs[0] = '{4'h0, 4'h0, 4'h0};
        vecs[1] = '{4'h1, 4'h0, 4'h1};
        vecs[2] = '{4'hC, 4'h3, 4'hF};
        vecs[3] = '{4'h8, 4'h8, 4'h8};
        vecs[4] = '{4'h6, 4'h3, 4'h7};
        vecs[5] = '{4'hF, 4'h0, 4'hF};
        vecs[6] = '{4'h0, 4'h4, 4'h4};
        vecs[7] = '{4'h9, 4'h2, 4'hB};

        #12;
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_res", res, 0);
        chk("rst_op_cnt", op_cnt, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        load(4'b1010, 4'b0101, 4'b1111);
        accept();

        for (int i = 0; i < 8; i++) begin
            load(vecs[i].a, vecs[i].b, vecs[i].exp);
`ifdef ALU_OPSEQ_ZERO_EN
            chk("res_zero", res_zero, vecs[i].exp == 0);
`endif
            accept();
        end

        // stall in RESULT; upstream words offered meanwhile must be ignored
        load(4'h2, 4'h4, 4'h6);
        in_valid = 1'b1;
        in_data = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_res", res, 4'h6);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_op_cnt", op_cnt, cnt);
            chk("stall_op_a", op_a, 4'h2);
        end
        in_valid = 1'b0;
        accept();

        // flush in LOAD_B with a word offered: word discarded
        in_valid = 1'b1;
        in_data = 4'h3;
        step();
        in_data = 4'h7;
        flush = 1'b1;
        chk("flush_in_ready", in_ready, 1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_op_b_kept", op_b, 4'h4);
        chk("flush_op_a_kept", op_a, 4'h3);
        chk("flush_back_to_a", in_ready, 1);
        load(4'h8, 4'h1, 4'h9);
        accept();

        // flush together with out_ready in RESULT: no count
        load(4'h5, 4'h0, 4'h5);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b0;
        chk("flush_hs_out_valid", out_valid, 0);
        chk("flush_hs_op_cnt", op_cnt, cnt);
        chk("flush_hs_res", res, 4'h5);
        chk("flush_hs_in_ready", in_ready, 1);

        // flush in EXEC: result must not be captured
        in_valid = 1'b1;
        in_data = 4'hA;
        step();
        in_data = 4'h1;
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_exec_res", res, 4'h5);
        chk("flush_exec_out_valid", out_valid, 0);
        chk("flush_exec_in_ready", in_ready, 1);

        // run to the counter wrap
        out_ready = 1'b1;
        while (cnt != 8'hFF) begin
            in_valid = 1'b1;
            in_data = 4'h1;
            step();
            in_data = 4'h2;
            step();
            in_valid = 1'b0;
            step();
            step();
            cnt++;
        end
        chk("pre_wrap_op_cnt", op_cnt, 8'hFF);
        out_ready = 1'b0;
        load(4'h4, 4'h1, 4'h5);
        accept();
        chk("wrap_op_cnt", op_cnt, 0);

        // async reset pulsed in EXEC
        in_valid = 1'b1;
        in_data = 4'h9;
        step();
        in_data = 4'h6;
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("exec_rst_op_a", op_a, 0);
        chk("exec_rst_op_b", op_b, 0);
        chk("exec_rst_res", res, 0);
        chk("exec_rst_op_cnt", op_cnt, 0);
        chk("exec_rst_out_valid", out_valid, 0);
        chk("exec_rst_in_ready", in_ready, 1);
        #1;
        rst_n = 1'b1;
        cnt = '0;
        step();
        chk("post_rst_res", res, 0);
        chk("post_rst_out_valid", out_valid, 0);
        load(4'h3, 4'h4, 4'h7);
        accept();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
